// File: rtl/uart_tx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame_ctrl_if
//  Description : Handshake / status bundle between a word producer (master)
//                and the UART transmit frame sequencer (slave).
//                  tx_data  : word to send, sampled only on accept
//                  tx_valid : tx_data valid
//                  tx_ready : sequencer idle, can accept a word
//                  tx       : serial line, idle high
//                  tx_busy  : frame in progress
//                  tx_done  : one-cycle pulse after the final stop bit
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_parity
//  Description : Combinational parity bit generator for one data word.
//                  i_data   : word to protect
//                  o_parity : "even" -> XOR of data, "odd" -> inverted XOR,
//                             "mark" -> 1, anything else -> 0
//  Revision    : 1.0  initial release
// ============================================================================
module uart_parity #(
    parameter int DATA_WIDTH  = 8,
    parameter     PARITY_TYPE = "none"
) (
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_parity
);
    always_comb begin
        if (PARITY_TYPE == "even")
            o_parity = ^i_data;
        else if (PARITY_TYPE == "odd")
            o_parity = ~(^i_data);
        else if (PARITY_TYPE == "mark")
            o_parity = 1'b1;
        else
            o_parity = 1'b0;
    end
endmodule

// ============================================================================
//  Module      : uart_tx_frame_ctrl
//  Description : UART transmit frame sequencer. Accepts one word per
//                valid/ready handshake and shifts it out LSB first as
//                start, data, optional parity and stop bit(s).
//                  clk  : system clock, rising edge
//                  rst  : asynchronous active-high reset
//                  bus  : slave side of uart_tx_frame_ctrl_if
//                         (tx_data/tx_valid in; tx_ready/tx/tx_busy/tx_done out)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter     PARITY_TYPE  = "none",
    parameter int STOP_BITS    = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uart_tx_frame_ctrl_if.slave   bus
);
    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // The bit index serves both the data bits and the stop-bit count.
    localparam int c_IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    // Unrecognised parity strings fall back to no parity slot at all.
    localparam bit c_PAR_EN = (PARITY_TYPE == "even") || (PARITY_TYPE == "odd") ||
                              (PARITY_TYPE == "mark") || (PARITY_TYPE == "space");

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_tx;
    logic                  r_done;
    logic                  w_tx_next;
    logic                  w_done_next;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_bit_end;
    logic                  w_parity;

    assign w_bit_end = (r_timer == c_TMR_LAST);
    assign w_accept  = bus.tx_valid && w_ready;

    // Parity always looks at the latched word, so tx_data may change freely
    // once a frame is in flight.
    uart_parity #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_parity (
        .i_data   (r_data),
        .o_parity (w_parity)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state and next bit index
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.tx_valid)
                    w_state_next = c_START;
            end
            c_START: begin
                if (w_bit_end)
                    w_state_next = c_DATA;
            end
            c_DATA: begin
                if (w_bit_end && (r_idx == c_DATA_LAST))
                    w_state_next = c_PAR_EN ? c_PARITY : c_STOP;
            end
            c_PARITY: begin
                if (w_bit_end)
                    w_state_next = c_STOP;
            end
            c_STOP: begin
                if (w_bit_end && (r_idx == c_STOP_LAST))
                    w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase

        // Index restarts on every state change and steps once per bit.
        w_idx_next = r_idx;
        if (w_state_next != r_state)
            w_idx_next = '0;
        else if (w_bit_end)
            w_idx_next = r_idx + c_IDX_W'(1);
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The line value is computed for the upcoming state so
    // that the registered tx changes on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready     = (r_state == c_IDLE);
        w_done_next = (r_state == c_STOP) && (w_state_next == c_IDLE);
        w_tx_next   = 1'b1;
        case (w_state_next)
            c_START:  w_tx_next = 1'b0;
            c_DATA:   w_tx_next = r_data[w_idx_next];
            c_PARITY: w_tx_next = w_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) || w_bit_end)
                r_timer <= '0;
            else
                r_timer <= r_timer + c_TMR_W'(1);
            r_idx  <= w_idx_next;
            r_tx   <= w_tx_next;
            r_done <= w_done_next;
            if (w_accept)
                r_data <= bus.tx_data;
        end
    end

    assign bus.tx_ready = w_ready;
    assign bus.tx_busy  = ~w_ready;
    assign bus.tx       = r_tx;
    assign bus.tx_done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame_ctrl
//  Description : Directed self-checking bench for uart_tx_frame_ctrl.
//                Five instances cover even/odd/none(2 stop)/mark/space
//                parity with CLKS_PER_BIT=4, DATA_WIDTH=8. Expected frames
//                are hand-packed, bit i = i-th bit on the line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;
    localparam int c_CPB = 4;
    localparam int c_DW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] r_data  = 8'h00;
    logic [4:0] r_valid = 5'b0;

    wire logic [4:0] w_tx;
    wire logic [4:0] w_rdy;
    wire logic [4:0] w_busy;
    wire logic [4:0] w_done;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(c_DW)) if_e ();
    uart_tx_frame_ctrl_if #(.DATA_WIDTH(c_DW)) if_o ();
    uart_tx_frame_ctrl_if #(.DATA_WIDTH(c_DW)) if_n ();
    uart_tx_frame_ctrl_if #(.DATA_WIDTH(c_DW)) if_m ();
    uart_tx_frame_ctrl_if #(.DATA_WIDTH(c_DW)) if_s ();

    uart_tx_frame_ctrl #(.CLKS_PER_BIT(c_CPB), .DATA_WIDTH(c_DW), .PARITY_TYPE("even"),  .STOP_BITS(1))
        u_even  (.clk(clk), .rst(rst), .bus(if_e));
    uart_tx_frame_ctrl #(.CLKS_PER_BIT(c_CPB), .DATA_WIDTH(c_DW), .PARITY_TYPE("odd"),   .STOP_BITS(1))
        u_odd   (.clk(clk), .rst(rst), .bus(if_o));
    uart_tx_frame_ctrl #(.CLKS_PER_BIT(c_CPB), .DATA_WIDTH(c_DW), .PARITY_TYPE("none"),  .STOP_BITS(2))
        u_none  (.clk(clk), .rst(rst), .bus(if_n));
    uart_tx_frame_ctrl #(.CLKS_PER_BIT(c_CPB), .DATA_WIDTH(c_DW), .PARITY_TYPE("mark"),  .STOP_BITS(1))
        u_mark  (.clk(clk), .rst(rst), .bus(if_m));
    uart_tx_frame_ctrl #(.CLKS_PER_BIT(c_CPB), .DATA_WIDTH(c_DW), .PARITY_TYPE("space"), .STOP_BITS(1))
        u_space (.clk(clk), .rst(rst), .bus(if_s));

    assign if_e.tx_data = r_data;  assign if_e.tx_valid = r_valid[0];
    assign if_o.tx_data = r_data;  assign if_o.tx_valid = r_valid[1];
    assign if_n.tx_data = r_data;  assign if_n.tx_valid = r_valid[2];
    assign if_m.tx_data = r_data;  assign if_m.tx_valid = r_valid[3];
    assign if_s.tx_data = r_data;  assign if_s.tx_valid = r_valid[4];

    assign w_tx[0] = if_e.tx; assign w_rdy[0] = if_e.tx_ready; assign w_busy[0] = if_e.tx_busy; assign w_done[0] = if_e.tx_done;
    assign w_tx[1] = if_o.tx; assign w_rdy[1] = if_o.tx_ready; assign w_busy[1] = if_o.tx_busy; assign w_done[1] = if_o.tx_done;
    assign w_tx[2] = if_n.tx; assign w_rdy[2] = if_n.tx_ready; assign w_busy[2] = if_n.tx_busy; assign w_done[2] = if_n.tx_done;
    assign w_tx[3] = if_m.tx; assign w_rdy[3] = if_m.tx_ready; assign w_busy[3] = if_m.tx_busy; assign w_done[3] = if_m.tx_done;
    assign w_tx[4] = if_s.tx; assign w_rdy[4] = if_s.tx_ready; assign w_busy[4] = if_s.tx_busy; assign w_done[4] = if_s.tx_done;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge. Presents word, waits for the accept edge, then
    // checks every cycle of the frame and the tx_done cycle that follows.
    // 'after' replaces tx_data right after accept; 'hold' keeps tx_valid high
    // (back-to-back); pulse_at >= 0 raises tx_valid for one cycle mid-frame.
    task automatic send_frame(input int sel, input logic [7:0] word, input logic [7:0] after,
                              input logic [15:0] frame, input int nbits, input bit hold,
                              input int pulse_at);
        r_data       = word;
        r_valid[sel] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < nbits * c_CPB; c++) begin
            @(negedge clk);
            if (c == 0) begin
                r_data = after;
                if (!hold) r_valid[sel] = 1'b0;
            end
            if (pulse_at >= 0 && c == pulse_at)     r_valid[sel] = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) r_valid[sel] = 1'b0;
            chk($sformatf("u%0d w%02h tx bit%0d cyc%0d", sel, word, c / c_CPB, c),
                32'(w_tx[sel]), 32'(frame[c / c_CPB]));
            chk($sformatf("u%0d w%02h ready cyc%0d", sel, word, c), 32'(w_rdy[sel]), 32'd0);
            chk($sformatf("u%0d w%02h busy cyc%0d", sel, word, c), 32'(w_busy[sel]), 32'd1);
            chk($sformatf("u%0d w%02h done early cyc%0d", sel, word, c), 32'(w_done[sel]), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("u%0d w%02h done pulse", sel, word), 32'(w_done[sel]), 32'd1);
        chk($sformatf("u%0d w%02h done tx", sel, word), 32'(w_tx[sel]), 32'd1);
        chk($sformatf("u%0d w%02h done ready", sel, word), 32'(w_rdy[sel]), 32'd1);
        chk($sformatf("u%0d w%02h done busy", sel, word), 32'(w_busy[sel]), 32'd0);
    endtask

    // Checks the line stays idle for n cycles (also catches wide tx_done).
    task automatic idle_check(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d idle tx %0d", sel, i), 32'(w_tx[sel]), 32'd1);
            chk($sformatf("u%0d idle ready %0d", sel, i), 32'(w_rdy[sel]), 32'd1);
            chk($sformatf("u%0d idle done %0d", sel, i), 32'(w_done[sel]), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        for (int u = 0; u < 5; u++) begin
            chk($sformatf("rst u%0d tx", u), 32'(w_tx[u]), 32'd1);
            chk($sformatf("rst u%0d ready", u), 32'(w_rdy[u]), 32'd1);
            chk($sformatf("rst u%0d busy", u), 32'(w_busy[u]), 32'd0);
            chk($sformatf("rst u%0d done", u), 32'(w_done[u]), 32'd0);
        end
        rst = 1'b0;
        idle_check(0, 2);

        // 1: even parity, 0xA5 -> 0,1,0,1,0,0,1,0,1,par0,stop1
        send_frame(0, 8'hA5, 8'h01, 16'h054A, 11, 1'b0, -1);
        idle_check(0, 2);

        // 2: odd parity; live data changed to opposite-parity word after accept
        send_frame(1, 8'h07, 8'h03, 16'h040E, 11, 1'b0, -1);
        idle_check(1, 2);
        send_frame(1, 8'h03, 8'h07, 16'h0606, 11, 1'b0, -1);
        idle_check(1, 2);

        // 3: no parity, two stop bits
        send_frame(2, 8'hFF, 8'h00, 16'h07FE, 11, 1'b0, -1);
        idle_check(2, 2);

        // 4: back-to-back with tx_valid held; second start bit right after done cycle
        send_frame(0, 8'h55, 8'hAA, 16'h04AA, 11, 1'b1, -1);
        send_frame(0, 8'hAA, 8'h00, 16'h0554, 11, 1'b0, -1);
        idle_check(0, 2);

        // 5: reset during data bit 3 of 0x0F (frame cycles 16..19)
        r_data     = 8'h0F;
        r_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk("abort pre tx", 32'(w_tx[0]), 32'd1);
        chk("abort pre busy", 32'(w_busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort tx", 32'(w_tx[0]), 32'd1);
        chk("abort busy", 32'(w_busy[0]), 32'd0);
        chk("abort ready", 32'(w_rdy[0]), 32'd1);
        chk("abort done", 32'(w_done[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort hold done", 32'(w_done[0]), 32'd0);
            chk("abort hold tx", 32'(w_tx[0]), 32'd1);
        end
        rst = 1'b0;
        idle_check(0, 3);
        send_frame(0, 8'h81, 8'h00, 16'h0502, 11, 1'b0, -1);
        idle_check(0, 2);

        // 6: mark/space constant parity; mid-frame valid pulse must be dropped
        send_frame(3, 8'h00, 8'hFF, 16'h0600, 11, 1'b0, 10);
        idle_check(3, 12);
        send_frame(3, 8'hFF, 8'h00, 16'h07FE, 11, 1'b0, -1);
        idle_check(3, 2);
        send_frame(4, 8'h00, 8'hFF, 16'h0400, 11, 1'b0, -1);
        idle_check(4, 2);
        send_frame(4, 8'hFF, 8'h00, 16'h05FE, 11, 1'b0, 20);
        idle_check(4, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
